// File: rtl/moving_avg_filter.sv
`default_nettype none
// ============================================================================
// Module   : moving_avg_filter
// Brief    : Boxcar (moving-average) filter over a runtime-selectable window
//            of 2^filt_sel samples (clamped to 2^MAX_LOG2). Keeps a running
//            sum: adds the newest sample and subtracts the one leaving the
//            window. The output is suppressed until the window is full.
// Options  : MOVING_AVG_ROUND_EN - round half up instead of truncating
// Revision : 1.0 - initial release
// ============================================================================
module moving_avg_filter #(
  parameter int BIT_WIDTH = 16,
  parameter int MAX_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic [2:0]           filt_sel,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] d,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] q,
  output logic                 primed
);

  localparam int         DEPTH     = 1 << MAX_LOG2;
  localparam int         ACC_W     = BIT_WIDTH + MAX_LOG2;
  localparam int         FILL_W    = MAX_LOG2 + 1;
  localparam logic [2:0] C_MAX_SEL = 3'(MAX_LOG2);

  // Registered state
  logic [2:0]           r_sel;
  logic [FILL_W-1:0]    r_fill;
  logic [MAX_LOG2-1:0]  r_wr_ptr;
  logic [ACC_W-1:0]     r_acc;
  logic [BIT_WIDTH-1:0] r_buf [DEPTH];

  // Next-state datapath
  logic [2:0]           w_sel_clamp;
  logic                 w_change;
  logic                 w_accept;
  logic [2:0]           w_sel_eff;
  logic [FILL_W-1:0]    w_n;
  logic [FILL_W-1:0]    w_fill_base;
  logic [ACC_W-1:0]     w_acc_base;
  logic [MAX_LOG2-1:0]  w_rd_ptr;
  logic [BIT_WIDTH-1:0] w_oldest;
  logic [ACC_W-1:0]     w_acc_next;
  logic [FILL_W-1:0]    w_fill_next;
  logic                 w_full_next;
  logic [BIT_WIDTH-1:0] w_avg;

  // Window selection, fill/accumulator bookkeeping and running-sum update.
  // A window change restarts fill and acc from zero in the same cycle, so a
  // sample arriving together with the change becomes the first of the new
  // window; the new window size is used for all decisions in that cycle.
  always_comb begin
    w_sel_clamp = (filt_sel > C_MAX_SEL) ? C_MAX_SEL : filt_sel;
    w_change    = (w_sel_clamp != r_sel);
    w_accept    = in_valid & ~sclr;
    w_sel_eff   = w_change ? w_sel_clamp : r_sel;
    w_n         = FILL_W'(1) << w_sel_eff;
    w_fill_base = w_change ? '0 : r_fill;
    w_acc_base  = w_change ? '0 : r_acc;
    // Entry N places behind the write pointer; for the largest window this
    // wraps onto the write pointer itself, read before it is overwritten.
    w_rd_ptr    = r_wr_ptr - w_n[MAX_LOG2-1:0];
    // Only subtract once the window is full; stale buffer entries never leak.
    w_oldest    = (w_fill_base == w_n) ? r_buf[w_rd_ptr] : '0;
    w_acc_next  = w_acc_base + ACC_W'(d) - ACC_W'(w_oldest);
    w_fill_next = (w_fill_base == w_n) ? w_fill_base : w_fill_base + FILL_W'(1);
    w_full_next = (w_fill_next == w_n);
  end

`ifdef MOVING_AVG_ROUND_EN
  logic [ACC_W:0] w_round_inc;
  logic [ACC_W:0] w_round_sum;

  // Round half up: add half an LSB of the result before shifting. The sum of
  // N samples plus N/2 shifted by log2(N) never exceeds the sample range.
  always_comb begin
    w_round_inc = (w_sel_eff == 3'd0) ? '0
                                      : ((ACC_W + 1)'(1) << (w_sel_eff - 3'd1));
    w_round_sum = {1'b0, w_acc_next} + w_round_inc;
    w_avg       = BIT_WIDTH'(w_round_sum >> w_sel_eff);
  end
`else
  // Truncating divide by the window length.
  always_comb begin
    w_avg = BIT_WIDTH'(w_acc_next >> w_sel_eff);
  end
`endif

  // Control state, running sum and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_fill    <= '0;
      r_wr_ptr  <= '0;
      r_acc     <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (sclr) begin
      r_sel     <= w_sel_clamp;
      r_fill    <= '0;
      r_wr_ptr  <= '0;
      r_acc     <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      r_sel     <= w_sel_eff;
      out_valid <= 1'b0;
      if (w_accept) begin
        r_acc    <= w_acc_next;
        r_fill   <= w_fill_next;
        r_wr_ptr <= r_wr_ptr + MAX_LOG2'(1);
        primed   <= w_full_next;
        if (w_full_next) begin
          q         <= w_avg;
          out_valid <= 1'b1;
        end
      end else if (w_change) begin
        r_acc  <= '0;
        r_fill <= '0;
        primed <= 1'b0;
      end
    end
  end

  // Sample history; never cleared because the fill gating hides stale data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= d;
    end
  end

endmodule
`default_nettype wire

// File: doc/moving_avg_filter.md
Name: moving_avg_filter

Overview:
Parametrised boxcar (moving-average) filter for one sample stream. The window is runtime-selectable as 2^filt_sel samples, up to 2^MAX_LOG2. It keeps a running sum: add the newest sample, subtract the one leaving the window. Input and output use a valid strobe. Output is suppressed until the window is full. Sits between the sample source (ADC or control-voltage path) and downstream DSP.

Parameters:
BIT_WIDTH, 16, sample width (unsigned)
MAX_LOG2, 4, log2 of the largest window; legal range 1..7; window storage is 2^MAX_LOG2 entries

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear, active high
filt_sel  in  3  requested window = 2^filt_sel; values above MAX_LOG2 clamp to MAX_LOG2
in_valid  in  1  d is a new sample this cycle
d  in  BIT_WIDTH  input sample
out_valid  out  1  one-cycle strobe: q holds a new average
q  out  BIT_WIDTH  averaged output
primed  out  1  high while the current window is full

Behaviour:
- Registered state:
  - sel_r: active log2 window. N = 1<<sel_r.
  - buffer: circular, 2^MAX_LOG2 x BIT_WIDTH.
  - wr_ptr: MAX_LOG2 bits, wraps modulo 2^MAX_LOG2.
  - fill: 0..N, saturating.
  - acc: BIT_WIDTH+MAX_LOG2 bits. It can never overflow.
- rst_n low, asynchronous: acc, fill, wr_ptr, sel_r, q, out_valid, primed all go to 0.
- Priority each cycle: sclr, then window change, then sample accept.
- sclr=1:
  - Next edge: acc, fill, wr_ptr, q, out_valid, primed go to 0.
  - sel_r loads the clamped filt_sel.
  - in_valid is ignored that cycle.
- Window change (clamped filt_sel != sel_r, sclr=0):
  - sel_r loads the new value; fill, acc and primed go to 0.
  - q holds its last value.
  - If in_valid is also high, that sample is accepted as the first sample of the new window (fill becomes 1, acc = d).
- Sample accept (in_valid=1, no sclr):
  - buffer[wr_ptr] <= d; wr_ptr++.
  - oldest = buffer[wr_ptr - N] (modulo 2^MAX_LOG2) when fill == N, else 0.
  - acc_next = acc + d - oldest.
  - fill_next = min(fill+1, N).
- Output, on an accept cycle where fill_next == N:
  - Next edge: q <= acc_next >> sel_r (truncating), out_valid <= 1.
- out_valid is 0 on every other cycle. q holds between strobes.
- Latency: accepted sample to out_valid is exactly 1 clock.
- primed <= (fill_next == N). It is cleared by window change, sclr and reset.
- Window 1 (filt_sel=0): q follows d with 1-cycle latency; out_valid = in_valid delayed one cycle.
- Gaps in in_valid: no state changes. The window counts samples, not clocks.
- Buffer contents are never cleared. The fill gating guarantees stale entries are never subtracted.
- Throughput: one sample per clock, sustained.

Optional Feature:
MOVING_AVG_ROUND_EN
- Defined:
  - q <= (acc_next + (1<<(sel_r-1))) >> sel_r for sel_r > 0, i.e. round half up.
  - The adder is one bit wider than acc.
  - The result cannot exceed 2^BIT_WIDTH-1, so no saturation logic is needed.
  - sel_r = 0 is unchanged.
- Undefined: plain truncation as in Behaviour. No extra adder.

Test Plan:
1. filt_sel=0, in_valid continuous, d = 5, 9, 0xFFFF → q = 5, 9, 0xFFFF, each one clock after its input, with out_valid high each cycle.
2. filt_sel=2, d = 4, 8, 12, 16, 20 → out_valid first high after the 4th sample with q=10 and primed=1; then q=14 after the 5th sample.
3. filt_sel=4 (MAX_LOG2=4), 16+ samples of 0xFFFF → q=0xFFFF with no overflow. filt_sel=7 clamps to window 16.
4. filt_sel=2, samples 4, 8, 12, 16 with in_valid low for 3 cycles between samples → same results as scenario 2. out_valid is strobed only on accept edges.
5. Window full at filt_sel=2, switch to filt_sel=1 together with d=6 valid, then d=10 → primed drops; the next out_valid gives q=8. q holds its old value in between.
6. sclr asserted mid-window with in_valid=1 → sample is ignored; the next 4 samples at window 4 are needed before out_valid. Separately, rst_n pulse mid-stream clears q and out_valid immediately (without a clock edge). With MOVING_AVG_ROUND_EN, filt_sel=1 and d = 1, 2 → q=2; without it → q=1.
